// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO over a register array with occupancy count, threshold flags
// and registered overflow/underflow pulses; FWFT selects registered or fall-through reads.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = 4,
  parameter int AF_LEVEL  = 14,
  parameter int AE_LEVEL  = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     data_out,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_SIZE:0]   FULL_CNT = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0]   AF_CNT   = (ADDR_SIZE+1)'(AF_LEVEL);
  localparam logic [ADDR_SIZE:0]   AE_CNT   = (ADDR_SIZE+1)'(AE_LEVEL);
  localparam logic [ADDR_SIZE:0]   CNT_ONE  = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);

  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_r;
  logic [ADDR_SIZE-1:0] rd_ptr_r;
  logic [ADDR_SIZE:0]   count_r;
  logic [ADDR_SIZE:0]   count_nxt_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 afull_r;
  logic                 aempty_r;
  logic                 ovf_r;
  logic                 udf_r;
  logic                 rd_acc_s;
  logic                 wr_acc_s;

  // Accept decisions and next occupancy; a read at full frees the slot for a same-cycle write.
  always_comb begin
    rd_acc_s    = rd_en & ~empty_r;
    wr_acc_s    = wr_en & (~full_r | rd_acc_s);
    count_nxt_s = count_r;
    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (rd_acc_s && !wr_acc_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy, flags decoded from the next count, and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {ADDR_SIZE{1'b0}};
      rd_ptr_r <= {ADDR_SIZE{1'b0}};
      count_r  <= {(ADDR_SIZE+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_acc_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == FULL_CNT);
      empty_r  <= (count_nxt_s == {(ADDR_SIZE+1){1'b0}});
      afull_r  <= (count_nxt_s >= AF_CNT);
      aempty_r <= (count_nxt_s <= AE_CNT);
      ovf_r    <= wr_en & ~wr_acc_s;
      udf_r    <= rd_en & ~rd_acc_s;
    end
  end

  // Storage array write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) mem_r[wr_ptr_r] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] dout_r;
      // Registered read: word captured on the accepting edge, held otherwise.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_r <= {WIDTH{1'b0}};
        end else if (rd_acc_s) begin
          dout_r <= mem_r[rd_ptr_r];
        end else begin
          dout_r <= dout_r;
        end
      end
      assign data_out = dout_r;
    end else begin : g_fwft
      assign data_out = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    end
  endgenerate

  assign count        = count_r;
  assign fifo_full    = full_r;
  assign fifo_empty   = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a queue model checked every cycle against a
// registered-read and a fall-through instance driven by the same stimulus.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [4:0] cnt_s, cnt_f;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] q[$];
  logic [7:0] e_dout = 8'h00;
  logic       e_ovf = 1'b0;
  logic       e_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .ADDR_SIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_s), .fifo_full(full_s), .fifo_empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(cnt_s), .overflow(ovf_s), .underflow(udf_s));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .ADDR_SIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_f), .fifo_full(full_f), .fifo_empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f), .underflow(udf_f));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Queue model: a read needs a stored word; a write needs room or a same-cycle pop.
  task automatic model_step();
    bit rd_ok, wr_ok;
    if (!rst) begin
      q.delete();
      e_dout = 8'h00;
      e_ovf  = 1'b0;
      e_udf  = 1'b0;
    end else begin
      rd_ok = rd_en && (q.size() != 0);
      wr_ok = wr_en && ((q.size() < 16) || rd_ok);
      e_ovf = wr_en && !wr_ok;
      e_udf = rd_en && !rd_ok;
      if (rd_ok) e_dout = q.pop_front();
      if (wr_ok) q.push_back(data_in);
    end
  endtask

  always @(posedge clk or negedge rst) model_step();

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int n;
    logic [7:0] ef;
    n  = q.size();
    ef = (n != 0) ? q[0] : 8'h00;
    chk("count",        {27'd0, cnt_s},   n);
    chk("fifo_full",    {31'd0, full_s},  {31'd0, n == 16});
    chk("fifo_empty",   {31'd0, empty_s}, {31'd0, n == 0});
    chk("almost_full",  {31'd0, af_s},    {31'd0, n >= 14});
    chk("almost_empty", {31'd0, ae_s},    {31'd0, n <= 2});
    chk("overflow",     {31'd0, ovf_s},   {31'd0, e_ovf});
    chk("underflow",    {31'd0, udf_s},   {31'd0, e_udf});
    chk("data_out",     {24'd0, dout_s},  {24'd0, e_dout});
    chk("fwft_count",   {27'd0, cnt_f},   n);
    chk("fwft_flags",   {26'd0, full_f, empty_f, af_f, ae_f, ovf_f, udf_f},
        {26'd0, n == 16, n == 0, n >= 14, n <= 2, e_ovf, e_udf});
    chk("fwft_data",    {24'd0, dout_f},  {24'd0, ef});
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_empty", {31'd0, empty_s}, 32'd1);
    chk("rst_ae",    {31'd0, ae_s},    32'd1);
    chk("rst_count", {27'd0, cnt_s},   32'd0);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);

    // Fill and drain in order; the fall-through instance shows the head right away.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i + 1));
      if (i == 0) chk("fwft_first", {24'd0, dout_f}, 32'h01);
    end
    chk("full_16", {26'd0, full_s, cnt_s}, {26'd0, 1'b1, 5'd16});
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("rd_order", {24'd0, dout_s}, 32'(i + 1));
    end
    step(1'b0, 1'b0, 8'h00);
    chk("drained", {26'd0, empty_s, cnt_s}, {26'd0, 1'b1, 5'd0});

    // Overflow at full, then a simultaneous read/write keeps it full.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i + 1));
    step(1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", {31'd0, ovf_s}, 32'd1);
    step(1'b1, 1'b1, 8'hAA);
    chk("ovf_clear", {31'd0, ovf_s}, 32'd0);
    chk("full_rw",   {27'd0, cnt_s}, 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    chk("aa_last", {24'd0, dout_s}, 32'hAA);

    // Underflow on empty, including the write-accepted/read-rejected case.
    step(1'b0, 1'b1, 8'h00);
    chk("udf_pulse", {31'd0, udf_s}, 32'd1);
    step(1'b1, 1'b1, 8'h5A);
    chk("udf_rw", {26'd0, udf_s, cnt_s}, {26'd0, 1'b1, 5'd1});
    step(1'b0, 1'b1, 8'h00);
    chk("rd_5a", {23'd0, udf_s, dout_s}, {23'd0, 1'b0, 8'h5A});

    // Threshold crossings while filling and draining one word at a time.
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 8'(k));
      if (k == 2)  chk("ae_at_2",  {31'd0, ae_s}, 32'd1);
      if (k == 3)  chk("ae_at_3",  {31'd0, ae_s}, 32'd0);
      if (k == 13) chk("af_at_13", {31'd0, af_s}, 32'd0);
      if (k == 14) chk("af_at_14", {31'd0, af_s}, 32'd1);
    end
    for (int k = 15; k >= 0; k--) begin
      step(1'b0, 1'b1, 8'h00);
      if (k == 13) chk("af_drain_13", {31'd0, af_s}, 32'd0);
      if (k == 3)  chk("ae_drain_3",  {31'd0, ae_s}, 32'd0);
      if (k == 2)  chk("ae_drain_2",  {31'd0, ae_s}, 32'd1);
    end

    // Alternating write/read across several pointer wraps.
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) step(1'b1, 1'b0, 8'(8'h30 + c / 2));
      else begin
        step(1'b0, 1'b1, 8'h00);
        chk("wrap_data", {24'd0, dout_s}, 32'(8'h30 + c / 2));
      end
      chk("wrap_cnt", {31'd0, cnt_s <= 5'd1}, 32'd1);
    end

    // Asynchronous reset mid-cycle with data stored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b0, 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", {21'd0, cnt_s, empty_s, full_s, ae_s, af_s, ovf_s, udf_s},
        {21'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("arst_dout", {16'd0, dout_s, dout_f}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_udf", {23'd0, udf_s, dout_s}, {23'd0, 1'b1, 8'h00});
    step(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
